// File: rtl/fetch_group_sender.sv
// Fetch-side producer: issues one I-cache line request at a time and turns the 4-word line into a
// lane-aligned instruction group. Define FETCH_PERF_CNT_EN to enable the group/stall counters.
module fetch_group_sender #(
    parameter int          CKPT_W   = 18,
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic [31:0]           flush_pc_i,
    output logic                  icache_req_o,
    output logic [31:0]           icache_addr_o,
    input  logic                  icache_ready_i,
    input  logic                  icache_rvalid_i,
    input  logic [127:0]          icache_rdata_i,
    input  logic                  icache_exc_i,
    input  logic [4:0]            icache_excCode_i,
    input  logic                  icache_refill_i,
    input  logic [3:0]            bp_take_i,
    input  logic [127:0]          bp_dest_i,
    input  logic [4*CKPT_W-1:0]   bp_info_i,
    input  logic                  ID_stopFetch_i,
    output logic                  IF_valid_o,
    output logic [3:0]            IF_instEnable_o,
    output logic [2:0]            IF_instNum_o,
    output logic [31:0]           IF_instBasePC_o,
    output logic [127:0]          IF_inst_p_o,
    output logic [127:0]          IF_predDest_p_o,
    output logic [3:0]            IF_predTake_p_o,
    output logic [4*CKPT_W-1:0]   IF_predInfo_p_o,
    output logic                  IF_hasException_o,
    output logic [4:0]            IF_ExcCode_o,
    output logic                  IF_isRefill_o,
    output logic [31:0]           perf_groups_o,
    output logic [31:0]           perf_stall_o
);
    typedef enum logic [2:0] {RUN, WAIT, DS_REQ, DS_WAIT, DRAIN, HALT} state_t;

    state_t               state_reg, state_next;
    logic [31:0]          pc_reg, pc_next;
    logic [31:0]          tgt_reg, tgt_next;
    logic                 req_accept;

    logic [31:0]          line_word [4];
    logic [1:0]           off;
    logic [2:0]           avail;
    logic [127:0]         rot_inst;
    logic                 take_found;
    logic [1:0]           take_lane;
    logic                 ds_needed;
    logic [2:0]           grp_num;
    logic [3:0]           grp_en;
    logic [31:0]          line_next_pc;

    logic                 valid_reg, valid_next;
    logic [3:0]           en_reg, en_next;
    logic [2:0]           num_reg, num_next;
    logic [31:0]          base_reg, base_next;
    logic [127:0]         inst_reg, inst_next;
    logic [127:0]         dest_reg, dest_next;
    logic [3:0]           take_reg, take_next;
    logic [4*CKPT_W-1:0]  info_reg, info_next;
    logic                 exc_reg, exc_next;
    logic [4:0]           code_reg, code_next;
    logic                 refill_reg, refill_next;

    assign off          = pc_reg[3:2];
    assign avail        = 3'd4 - {1'b0, off};
    assign line_next_pc = {pc_reg[31:4] + 28'd1, 4'b0000};

    // Lane i carries the word at fetch PC + 4*i within the line.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [1:0] src;
            assign line_word[gi]          = icache_rdata_i[32*gi +: 32];
            assign src                    = off + 2'(gi);
            assign rot_inst[32*gi +: 32]  = line_word[src];
        end
    endgenerate

    always_comb begin
        take_found = 1'b0;
        take_lane  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (bp_take_i[i] && (3'(i) < avail)) begin
                take_found = 1'b1;
                take_lane  = 2'(i);
            end
        end
    end

    // A taken branch in the last valid lane leaves its delay slot in the next line.
    assign ds_needed = take_found && (({1'b0, take_lane} + 3'd1) == avail);
    assign grp_num   = (take_found && !ds_needed) ? ({1'b0, take_lane} + 3'd2) : avail;
    assign grp_en    = 4'((5'd1 << grp_num) - 5'd1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= RUN;
            pc_reg     <= RESET_PC;
            tgt_reg    <= '0;
            valid_reg  <= 1'b0;
            en_reg     <= '0;
            num_reg    <= '0;
            base_reg   <= '0;
            inst_reg   <= '0;
            dest_reg   <= '0;
            take_reg   <= '0;
            info_reg   <= '0;
            exc_reg    <= 1'b0;
            code_reg   <= '0;
            refill_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            tgt_reg    <= tgt_next;
            valid_reg  <= valid_next;
            en_reg     <= en_next;
            num_reg    <= num_next;
            base_reg   <= base_next;
            inst_reg   <= inst_next;
            dest_reg   <= dest_next;
            take_reg   <= take_next;
            info_reg   <= info_next;
            exc_reg    <= exc_next;
            code_reg   <= code_next;
            refill_reg <= refill_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        tgt_next    = tgt_reg;
        valid_next  = 1'b0;
        en_next     = '0;
        num_next    = '0;
        base_next   = '0;
        inst_next   = '0;
        dest_next   = '0;
        take_next   = '0;
        info_next   = '0;
        exc_next    = 1'b0;
        code_next   = '0;
        refill_next = 1'b0;
        if (flush_i) begin
            pc_next = flush_pc_i;
            if ((state_reg == WAIT || state_reg == DS_WAIT || state_reg == DRAIN) && !icache_rvalid_i)
                state_next = DRAIN;
            else
                state_next = RUN;
        end else begin
            case (state_reg)
                RUN:     if (req_accept) state_next = WAIT;
                DS_REQ:  if (req_accept) state_next = DS_WAIT;
                WAIT, DS_WAIT: begin
                    if (icache_rvalid_i) begin
                        valid_next = 1'b1;
                        base_next  = pc_reg;
                        if (icache_exc_i) begin
                            en_next     = 4'b0001;
                            num_next    = 3'd1;
                            inst_next   = rot_inst;
                            exc_next    = 1'b1;
                            code_next   = icache_excCode_i;
                            refill_next = icache_refill_i;
                            state_next  = HALT;
                        end else if (state_reg == DS_WAIT) begin
                            en_next    = 4'b0001;
                            num_next   = 3'd1;
                            inst_next  = icache_rdata_i;
                            dest_next  = bp_dest_i;
                            info_next  = bp_info_i;
                            pc_next    = tgt_reg;
                            state_next = RUN;
                        end else begin
                            en_next   = grp_en;
                            num_next  = grp_num;
                            inst_next = rot_inst;
                            dest_next = bp_dest_i;
                            take_next = bp_take_i & grp_en;
                            info_next = bp_info_i;
                            if (!take_found) begin
                                pc_next    = line_next_pc;
                                state_next = RUN;
                            end else if (!ds_needed) begin
                                pc_next    = bp_dest_i[32*take_lane +: 32];
                                state_next = RUN;
                            end else begin
                                tgt_next   = bp_dest_i[32*take_lane +: 32];
                                pc_next    = line_next_pc;
                                state_next = DS_REQ;
                            end
                        end
                    end
                end
                DRAIN:   if (icache_rvalid_i) state_next = RUN;
                HALT:    state_next = HALT;
                default: state_next = RUN;
            endcase
        end
    end

    always_comb begin
        icache_req_o = ((state_reg == RUN) || (state_reg == DS_REQ)) && !ID_stopFetch_i && !flush_i;
    end

    assign req_accept        = icache_req_o && icache_ready_i;
    assign icache_addr_o     = pc_reg;
    assign IF_valid_o        = valid_reg;
    assign IF_instEnable_o   = en_reg;
    assign IF_instNum_o      = num_reg;
    assign IF_instBasePC_o   = base_reg;
    assign IF_inst_p_o       = inst_reg;
    assign IF_predDest_p_o   = dest_reg;
    assign IF_predTake_p_o   = take_reg;
    assign IF_predInfo_p_o   = info_reg;
    assign IF_hasException_o = exc_reg;
    assign IF_ExcCode_o      = code_reg;
    assign IF_isRefill_o     = refill_reg;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_groups_reg, perf_stall_reg;
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_groups_reg <= '0;
            perf_stall_reg  <= '0;
        end else begin
            if (valid_reg)
                perf_groups_reg <= perf_groups_reg + 32'd1;
            if ((state_reg == RUN || state_reg == DS_REQ) && ID_stopFetch_i)
                perf_stall_reg <= perf_stall_reg + 32'd1;
        end
    end
    assign perf_groups_o = perf_groups_reg;
    assign perf_stall_o  = perf_stall_reg;
`else
    assign perf_groups_o = '0;
    assign perf_stall_o  = '0;
`endif
endmodule

// File: tb/tb_fetch_group_sender.sv
// Randomized scoreboard bench for fetch_group_sender: a cache responder plus fetch-sequence model
// pushes expected groups; a monitor pops and compares on every IF_valid_o.
module tb_fetch_group_sender;
    localparam int CKPT_W = 18;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush_i;
    logic [31:0]          flush_pc_i;
    logic                 icache_req_o;
    logic [31:0]          icache_addr_o;
    logic                 icache_ready_i;
    logic                 icache_rvalid_i;
    logic [127:0]         icache_rdata_i;
    logic                 icache_exc_i;
    logic [4:0]           icache_excCode_i;
    logic                 icache_refill_i;
    logic [3:0]           bp_take_i;
    logic [127:0]         bp_dest_i;
    logic [4*CKPT_W-1:0]  bp_info_i;
    logic                 ID_stopFetch_i;
    logic                 IF_valid_o;
    logic [3:0]           IF_instEnable_o;
    logic [2:0]           IF_instNum_o;
    logic [31:0]          IF_instBasePC_o;
    logic [127:0]         IF_inst_p_o;
    logic [127:0]         IF_predDest_p_o;
    logic [3:0]           IF_predTake_p_o;
    logic [4*CKPT_W-1:0]  IF_predInfo_p_o;
    logic                 IF_hasException_o;
    logic [4:0]           IF_ExcCode_o;
    logic                 IF_isRefill_o;
    logic [31:0]          perf_groups_o;
    logic [31:0]          perf_stall_o;

    always #5 clk = ~clk;

    fetch_group_sender #(.CKPT_W(CKPT_W), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
        .icache_req_o(icache_req_o), .icache_addr_o(icache_addr_o), .icache_ready_i(icache_ready_i),
        .icache_rvalid_i(icache_rvalid_i), .icache_rdata_i(icache_rdata_i), .icache_exc_i(icache_exc_i),
        .icache_excCode_i(icache_excCode_i), .icache_refill_i(icache_refill_i),
        .bp_take_i(bp_take_i), .bp_dest_i(bp_dest_i), .bp_info_i(bp_info_i),
        .ID_stopFetch_i(ID_stopFetch_i), .IF_valid_o(IF_valid_o), .IF_instEnable_o(IF_instEnable_o),
        .IF_instNum_o(IF_instNum_o), .IF_instBasePC_o(IF_instBasePC_o), .IF_inst_p_o(IF_inst_p_o),
        .IF_predDest_p_o(IF_predDest_p_o), .IF_predTake_p_o(IF_predTake_p_o),
        .IF_predInfo_p_o(IF_predInfo_p_o), .IF_hasException_o(IF_hasException_o),
        .IF_ExcCode_o(IF_ExcCode_o), .IF_isRefill_o(IF_isRefill_o),
        .perf_groups_o(perf_groups_o), .perf_stall_o(perf_stall_o)
    );

    typedef struct packed {
        logic [3:0]          en;
        logic [2:0]          num;
        logic [31:0]         base;
        logic [127:0]        inst;
        logic [3:0]          take;
        logic [127:0]        dest;
        logic [4*CKPT_W-1:0] info;
        logic                exc;
        logic [4:0]          code;
        logic                refill;
        logic                chk_inst;
        logic                chk_pred;
    } grp_t;

    grp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   groups_seen = 0;

    // Reference fetch state: next request address, delay-slot pending, target, halted.
    logic [31:0] m_pc, m_tgt, m_req_pc;
    bit          m_ds, m_req_ds, m_halt;
    bit          outstanding, discard;
    int          lat, halt_cycles;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    function automatic logic [127:0] inst_mask(input logic [3:0] en);
        logic [127:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) if (en[i]) m[32*i +: 32] = '1;
        return m;
    endfunction

    function automatic logic [4*CKPT_W-1:0] info_mask(input logic [3:0] en);
        logic [4*CKPT_W-1:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) if (en[i]) m[CKPT_W*i +: CKPT_W] = '1;
        return m;
    endfunction

    grp_t me;
    always @(negedge clk) begin
        if (rst && IF_valid_o) begin
            groups_seen++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_group got base=%h en=%b required no group", IF_instBasePC_o, IF_instEnable_o);
            end else begin
                me = exp_q.pop_front();
                check("grp_en", 128'(IF_instEnable_o), 128'(me.en));
                check("grp_num", 128'(IF_instNum_o), 128'(me.num));
                check("grp_base", 128'(IF_instBasePC_o), 128'(me.base));
                check("grp_exc", 128'(IF_hasException_o), 128'(me.exc));
                check("grp_code", 128'(IF_ExcCode_o), 128'(me.code));
                check("grp_refill", 128'(IF_isRefill_o), 128'(me.refill));
                check("grp_take", 128'(IF_predTake_p_o & me.en), 128'(me.take & me.en));
                if (me.chk_inst)
                    check("grp_inst", IF_inst_p_o & inst_mask(me.en), me.inst & inst_mask(me.en));
                if (me.chk_pred) begin
                    check("grp_dest", IF_predDest_p_o & inst_mask(me.en), me.dest & inst_mask(me.en));
                    check("grp_info", 128'(IF_predInfo_p_o & info_mask(me.en)), 128'(me.info & info_mask(me.en)));
                end
                $display("[TB] group base=%h en=%b num=%0d exc=%0b", IF_instBasePC_o, IF_instEnable_o,
                         IF_instNum_o, IF_hasException_o);
            end
        end
    end

    // Expected group for the response now on the cache inputs, and the next fetch address.
    task automatic model_response(input logic [31:0] w [4]);
        grp_t e;
        int off, avail, t, n;
        logic [31:0] line_next;
        e = '0;
        e.base = m_req_pc;
        off = int'(m_req_pc[3:2]);
        avail = 4 - off;
        line_next = (m_req_pc & 32'hFFFF_FFF0) + 32'd16;
        if (icache_exc_i) begin
            e.en = 4'b0001; e.num = 3'd1; e.exc = 1'b1;
            e.code = icache_excCode_i; e.refill = icache_refill_i;
            m_halt = 1'b1;
            halt_cycles = 0;
        end else if (m_req_ds) begin
            e.en = 4'b0001; e.num = 3'd1; e.chk_inst = 1'b1;
            e.inst[31:0] = w[0];
            m_pc = m_tgt;
            m_ds = 1'b0;
        end else begin
            for (int i = 0; i < avail; i++) e.inst[32*i +: 32] = w[(off + i) % 4];
            t = -1;
            for (int i = 0; i < avail; i++) if (bp_take_i[i] && t < 0) t = i;
            if (t < 0) begin
                n = avail;
                m_pc = line_next;
            end else if (t < avail - 1) begin
                n = t + 2;
                m_pc = bp_dest_i[32*t +: 32];
            end else begin
                n = avail;
                m_tgt = bp_dest_i[32*t +: 32];
                m_pc = line_next;
                m_ds = 1'b1;
            end
            e.num = 3'(n);
            e.en = 4'((1 << n) - 1);
            e.take = bp_take_i & e.en;
            e.dest = bp_dest_i;
            e.info = bp_info_i;
            e.chk_inst = 1'b1;
            e.chk_pred = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    // One clock of stimulus: starts and ends at a falling edge.
    task automatic cycle(input bit active);
        logic [31:0] r, r2, tmp;
        logic [31:0] w [4];
        bit resp_now, do_flush, exp_req;
        r = $urandom;
        r2 = $urandom;
        icache_rvalid_i = 1'b0;
        icache_exc_i = 1'b0;
        icache_excCode_i = '0;
        icache_refill_i = 1'b0;
        flush_i = 1'b0;
        icache_ready_i = active ? r[0] : 1'b0;
        ID_stopFetch_i = active ? (r[3:1] == 3'd0) : 1'b0;
        if (m_halt) halt_cycles++;
        do_flush = (m_halt && halt_cycles >= 4) || (active && r[8:4] == 5'd0);
        resp_now = outstanding && (lat == 0);
        if (outstanding && lat != 0) lat--;
        if (resp_now) begin
            for (int k = 0; k < 4; k++) begin
                w[k] = $urandom;
                icache_rdata_i[32*k +: 32] = w[k];
                tmp = $urandom;
                bp_dest_i[32*k +: 32] = {tmp[31:2], 2'b00};
                bp_info_i[CKPT_W*k +: CKPT_W] = CKPT_W'($urandom);
            end
            tmp = $urandom;
            bp_take_i = tmp[3:0] & tmp[7:4];
            icache_rvalid_i = 1'b1;
            icache_exc_i = active && (r[13:9] == 5'd0);
            icache_excCode_i = r2[4:0];
            icache_refill_i = r2[5];
            outstanding = 1'b0;
            if (!discard && !do_flush) model_response(w);
            discard = 1'b0;
        end
        if (do_flush) begin
            flush_i = 1'b1;
            tmp = $urandom;
            flush_pc_i = {tmp[31:2], 2'b00};
            m_pc = flush_pc_i;
            m_ds = 1'b0;
            m_halt = 1'b0;
            halt_cycles = 0;
            if (outstanding) discard = 1'b1;
        end
        #1;
        exp_req = !m_halt && !outstanding && !resp_now && !ID_stopFetch_i && !flush_i;
        check("req_valid", 128'(icache_req_o), 128'(exp_req));
        if (icache_req_o && icache_ready_i) begin
            check("req_addr", 128'(icache_addr_o), 128'(m_pc));
            outstanding = 1'b1;
            lat = $urandom_range(0, 3);
            m_req_pc = m_pc;
            m_req_ds = m_ds;
        end
        @(negedge clk);
    endtask

    logic [31:0] p0;
    initial begin
        rst = 1'b0;
        flush_i = 1'b0; flush_pc_i = '0;
        icache_ready_i = 1'b0; icache_rvalid_i = 1'b0; icache_rdata_i = '0;
        icache_exc_i = 1'b0; icache_excCode_i = '0; icache_refill_i = 1'b0;
        bp_take_i = '0; bp_dest_i = '0; bp_info_i = '0; ID_stopFetch_i = 1'b0;
        m_pc = RESET_PC; m_tgt = '0; m_req_pc = '0;
        m_ds = 1'b0; m_req_ds = 1'b0; m_halt = 1'b0;
        outstanding = 1'b0; discard = 1'b0; lat = 0; halt_cycles = 0;
        repeat (3) @(negedge clk);
        check("rst_valid", 128'(IF_valid_o), 128'(0));
        check("rst_en", 128'(IF_instEnable_o), 128'(0));
        check("rst_num", 128'(IF_instNum_o), 128'(0));
        check("rst_exc", 128'(IF_hasException_o), 128'(0));
        check("rst_addr", 128'(icache_addr_o), 128'(RESET_PC));
        check("rst_perf", 128'({perf_groups_o, perf_stall_o}), 128'(0));
        rst = 1'b1;

        for (int c = 0; c < 3000; c++) cycle(1'b1);

        for (int k = 0; k < 50 && (outstanding || m_halt); k++) cycle(1'b0);
        check("drain_done", 128'({outstanding, m_halt}), 128'(0));
        cycle(1'b0);

        // Hold stop-fetch with the cache ready: no request may leave.
        p0 = perf_stall_o;
        icache_ready_i = 1'b1;
        ID_stopFetch_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stop_req", 128'(icache_req_o), 128'(0));
            @(negedge clk);
        end
        ID_stopFetch_i = 1'b0;
        icache_ready_i = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        check("perf_stall", 128'(perf_stall_o - p0), 128'(5));
`else
        check("perf_stall", 128'(perf_stall_o - p0), 128'(0));
`endif
        repeat (3) @(negedge clk);
        check("queue_empty", 128'(exp_q.size()), 128'(0));
`ifdef FETCH_PERF_CNT_EN
        check("perf_groups", 128'(perf_groups_o), 128'(groups_seen));
`else
        check("perf_groups", 128'(perf_groups_o), 128'(0));
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
